// File: rtl/cu_write_arbiter_control_pkg.sv
// Shared types and constants for the write-channel arbiter and its neighbours.
// Optional feature macro used by the arbiter: CU_WRITE_ARBITER_BURST_EN.
package cu_write_arbiter_control_pkg;

    localparam logic [7:0] DATA_WRITE_CONTROL_ID     = 8'h10;
    localparam int         WRITE_ARB_MAX_OUTSTANDING = 32;
    localparam int         WRITE_ARB_BURST_LEN       = 4;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ACTIVE   = 2'd1,
        DRAIN    = 2'd2
    } write_arb_state_e;

    typedef struct packed {
        logic        valid;
        logic [7:0]  cu_id;
        logic [31:0] address;
        logic [7:0]  size;
    } CommandBufferLine;

    typedef struct packed {
        logic [31:0] data;
    } ReadWriteDataLine;

    typedef struct packed {
        logic [7:0] cu_id;
        logic [7:0] tag;
    } ResponseControl;

    typedef struct packed {
        logic           valid;
        ResponseControl cmd;
    } ResponseBufferLine;

    typedef struct packed {
        logic alfull;
    } BufferStatus;

endpackage

// File: rtl/cu_write_arbiter_control_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting at the
// priority pointer and returns a one-hot grant plus the winner's index.
module round_robin_priority_arbiter_N_input #(
    parameter int  NUM_INPUTS = 4,
    localparam int PTR_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic [NUM_INPUTS-1:0] request_in,
    input  logic [PTR_W-1:0]      pointer_in,
    output logic [NUM_INPUTS-1:0] grant_out,
    output logic                  grant_valid_out,
    output logic [PTR_W-1:0]      grant_index_out
);

    // First requester at or after the pointer (wrapping) wins.
    always_comb begin
        int   idx;
        logic found;
        // NOTE: every output gets a default before any branch so no latch is inferred.
        found           = 1'b0;
        idx             = 0;
        grant_out       = '0;
        grant_index_out = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = int'(pointer_in) + k;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            if (!found && request_in[idx]) begin
                found           = 1'b1;
                grant_out[idx]  = 1'b1;
                grant_index_out = PTR_W'(idx);
            end
        end
        grant_valid_out = found;
    end

endmodule

// File: rtl/cu_write_arbiter_control.sv
// Shares one write command/data channel among several write engine controls.
// Round-robin grant, credit-limited issue, response demux by cu_id, and a
// drain FSM for clean quiesce. Define CU_WRITE_ARBITER_BURST_EN to let a
// winner keep priority for up to WRITE_ARB_BURST_LEN consecutive grants.
module cu_write_arbiter_control
    import cu_write_arbiter_control_pkg::*;
#(
    parameter int         NUM_REQUESTERS  = 4,
    parameter logic [7:0] REQ_ID_BASE     = DATA_WRITE_CONTROL_ID,
    parameter int         MAX_OUTSTANDING = WRITE_ARB_MAX_OUTSTANDING,
    localparam int        PTR_W           = $clog2(NUM_REQUESTERS),
    localparam int        CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                   clock,
    input  logic                                   rst,
    input  logic                                   enabled_in,
    input  CommandBufferLine  [NUM_REQUESTERS-1:0] write_command_in,
    input  ReadWriteDataLine  [NUM_REQUESTERS-1:0] write_data_0_in,
    input  ReadWriteDataLine  [NUM_REQUESTERS-1:0] write_data_1_in,
    output logic              [NUM_REQUESTERS-1:0] request_ready_out,
    input  BufferStatus                            write_command_buffer_status,
    input  ResponseBufferLine                      write_response_in,
    output CommandBufferLine                       write_command_out,
    output ReadWriteDataLine                       write_data_0_out,
    output ReadWriteDataLine                       write_data_1_out,
    output ResponseBufferLine [NUM_REQUESTERS-1:0] write_response_out,
    output logic              [CNT_W-1:0]          outstanding_count,
    output logic                                   drained_out
);

    write_arb_state_e                       state_q, state_d;
    logic              [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic              [CNT_W-1:0]          outstanding_q, outstanding_d;
    CommandBufferLine                       cmd_q, cmd_d;
    ReadWriteDataLine                       data0_q, data0_d;
    ReadWriteDataLine                       data1_q, data1_d;
    ResponseBufferLine [NUM_REQUESTERS-1:0] resp_q, resp_d;

    logic                      can_issue;
    logic [NUM_REQUESTERS-1:0] req_vec;
    logic [NUM_REQUESTERS-1:0] grant;
    logic                      grant_valid;
    logic [PTR_W-1:0]          grant_idx;
    logic                      resp_dec;
    logic                      any_out_valid;

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQUESTERS - 1)) ? '0 : idx + PTR_W'(1);
    endfunction

    // Issue only while active, downstream has room and a credit is free.
    assign can_issue = (state_q == ACTIVE) && !write_command_buffer_status.alfull &&
                       (outstanding_q < CNT_W'(MAX_OUTSTANDING));

    // Requests are masked so the arbiter never grants when issue is blocked.
    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            req_vec[i] = write_command_in[i].valid && can_issue;
        end
    end

    round_robin_priority_arbiter_N_input #(
        .NUM_INPUTS (NUM_REQUESTERS)
    ) u_arbiter (
        .request_in      (req_vec),
        .pointer_in      (rr_ptr_q),
        .grant_out       (grant),
        .grant_valid_out (grant_valid),
        .grant_index_out (grant_idx)
    );

    assign request_ready_out = grant;

    // Winner's triple passes through unmodified; zeros when nothing is granted.
    always_comb begin
        cmd_d   = '0;
        data0_d = '0;
        data1_d = '0;
        if (grant_valid) begin
            cmd_d   = write_command_in[grant_idx];
            data0_d = write_data_0_in[grant_idx];
            data1_d = write_data_1_in[grant_idx];
        end
    end

    // Route each response to the requester owning its cu_id; unmatched ids are dropped.
    always_comb begin
        resp_d = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (write_response_in.valid &&
                write_response_in.cmd.cu_id == REQ_ID_BASE + 8'(i)) begin
                resp_d[i] = write_response_in;
            end
        end
    end

    // Credit counter: a grant takes one, any response returns one, never below zero.
    always_comb begin
        resp_dec      = write_response_in.valid && (outstanding_q != '0);
        outstanding_d = outstanding_q;
        case ({grant_valid, resp_dec})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Drain FSM: leave DRAIN for DISABLED only once credits and outputs are idle.
    always_comb begin
        any_out_valid = cmd_q.valid;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            any_out_valid = any_out_valid | resp_q[i].valid;
        end
        state_d = state_q;
        case (state_q)
            DISABLED: if (enabled_in) state_d = ACTIVE;
            ACTIVE:   if (!enabled_in) state_d = DRAIN;
            DRAIN: begin
                if (enabled_in) begin
                    state_d = ACTIVE;
                end else if (outstanding_q == '0 && !any_out_valid) begin
                    state_d = DISABLED;
                end
            end
            default:  state_d = DISABLED;
        endcase
    end

`ifdef CU_WRITE_ARBITER_BURST_EN
    logic [1:0] burst_cnt_q, burst_cnt_d;

    // Holder keeps priority until its 4th grant or until its request drops.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (grant_valid) begin
            if (grant_idx != rr_ptr_q) begin
                rr_ptr_d    = grant_idx;
                burst_cnt_d = 2'd1;
            end else if (burst_cnt_q == 2'(WRITE_ARB_BURST_LEN - 1)) begin
                rr_ptr_d    = ptr_after(grant_idx);
                burst_cnt_d = 2'd0;
            end else begin
                burst_cnt_d = burst_cnt_q + 2'd1;
            end
        end else if (burst_cnt_q != 2'd0 && !write_command_in[rr_ptr_q].valid) begin
            rr_ptr_d    = ptr_after(rr_ptr_q);
            burst_cnt_d = 2'd0;
        end
    end

    // Burst counter register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) burst_cnt_q <= 2'd0;
        else     burst_cnt_q <= burst_cnt_d;
    end
`else
    // Pure round-robin: priority moves just past every winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) rr_ptr_d = ptr_after(grant_idx);
    end
`endif

    // State, pointer, credits and registered outputs.
    always_ff @(posedge clock or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= DISABLED;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            cmd_q         <= '0;
            data0_q       <= '0;
            data1_q       <= '0;
            resp_q        <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            cmd_q         <= cmd_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            resp_q        <= resp_d;
        end
    end

    assign write_command_out  = cmd_q;
    assign write_data_0_out   = data0_q;
    assign write_data_1_out   = data1_q;
    assign write_response_out = resp_q;
    assign outstanding_count  = outstanding_q;
    assign drained_out        = (state_q == DISABLED);

endmodule

// File: tb/tb_cu_write_arbiter_control.sv
// Scoreboard bench for cu_write_arbiter_control: stimulus pushes expected
// issues/responses, a monitor pops and compares whenever the DUT shows them.
module tb_cu_write_arbiter_control;
    import cu_write_arbiter_control_pkg::*;

    localparam int         N     = 4;
    localparam int         CNT_W = $clog2(WRITE_ARB_MAX_OUTSTANDING + 1);
    localparam logic [7:0] BASE  = DATA_WRITE_CONTROL_ID;

    typedef struct packed {
        CommandBufferLine cmd;
        ReadWriteDataLine d0;
        ReadWriteDataLine d1;
    } triple_t;

    typedef struct packed {
        logic [7:0]        idx;
        ResponseBufferLine r;
    } resp_exp_t;

    logic                         clock = 1'b0;
    logic                         rst;
    logic                         enabled_in;
    CommandBufferLine  [N-1:0]    write_command_in;
    ReadWriteDataLine  [N-1:0]    write_data_0_in;
    ReadWriteDataLine  [N-1:0]    write_data_1_in;
    logic              [N-1:0]    request_ready_out;
    BufferStatus                  write_command_buffer_status;
    ResponseBufferLine            write_response_in;
    CommandBufferLine             write_command_out;
    ReadWriteDataLine             write_data_0_out;
    ReadWriteDataLine             write_data_1_out;
    ResponseBufferLine [N-1:0]    write_response_out;
    logic              [CNT_W-1:0] outstanding_count;
    logic                         drained_out;

    triple_t   exp_q[$];
    resp_exp_t resp_q[$];
    int        n_vec  = 0;
    int        n_miss = 0;
    int        phase  = 0;
    logic      en_drive = 1'b0;
    logic      af_drive = 1'b0;

    always #5 clock = ~clock;

    cu_write_arbiter_control #(
        .NUM_REQUESTERS  (N),
        .REQ_ID_BASE     (BASE),
        .MAX_OUTSTANDING (WRITE_ARB_MAX_OUTSTANDING)
    ) dut (
        .clock                       (clock),
        .rst                         (rst),
        .enabled_in                  (enabled_in),
        .write_command_in            (write_command_in),
        .write_data_0_in             (write_data_0_in),
        .write_data_1_in             (write_data_1_in),
        .request_ready_out           (request_ready_out),
        .write_command_buffer_status (write_command_buffer_status),
        .write_response_in           (write_response_in),
        .write_command_out           (write_command_out),
        .write_data_0_out            (write_data_0_out),
        .write_data_1_out            (write_data_1_out),
        .write_response_out          (write_response_out),
        .outstanding_count           (outstanding_count),
        .drained_out                 (drained_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic CommandBufferLine mk_cmd(input int i, input int ph);
        CommandBufferLine c;
        c.valid   = 1'b1;
        c.cu_id   = BASE + 8'(i);
        c.address = 32'hA000_0000 | (32'(ph) << 8) | 32'(i);
        c.size    = 8'h40;
        return c;
    endfunction

    function automatic ReadWriteDataLine mk_d0(input int i, input int ph);
        ReadWriteDataLine d;
        d.data = 32'hD000_0000 | (32'(ph) << 8) | 32'(i);
        return d;
    endfunction

    function automatic ReadWriteDataLine mk_d1(input int i, input int ph);
        ReadWriteDataLine d;
        d.data = 32'hE000_0000 | (32'(ph) << 12) | 32'(i);
        return d;
    endfunction

    // One clock of stimulus: drive at negedge, check ready, push expectations.
    task automatic step(input logic [N-1:0] req, input int exp_g,
                        input logic rv = 1'b0, input logic [7:0] rid = 8'h00,
                        input logic [7:0] rtag = 8'h00);
        logic [N-1:0] exp_ready;
        @(negedge clock);
        enabled_in                         = en_drive;
        write_command_buffer_status.alfull = af_drive;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                write_command_in[i] = mk_cmd(i, phase);
                write_data_0_in[i]  = mk_d0(i, phase);
                write_data_1_in[i]  = mk_d1(i, phase);
            end else begin
                write_command_in[i] = '0;
                write_data_0_in[i]  = '0;
                write_data_1_in[i]  = '0;
            end
        end
        write_response_in = '0;
        if (rv) begin
            write_response_in.valid     = 1'b1;
            write_response_in.cmd.cu_id = rid;
            write_response_in.cmd.tag   = rtag;
        end
        #1;
        exp_ready = '0;
        if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
        check($sformatf("ready_ph%0d", phase), 64'(request_ready_out), 64'(exp_ready));
        if (exp_g >= 0) exp_q.push_back('{cmd: mk_cmd(exp_g, phase), d0: mk_d0(exp_g, phase), d1: mk_d1(exp_g, phase)});
        if (rv) begin
            for (int i = 0; i < N; i++) begin
                if (rid == BASE + 8'(i)) resp_q.push_back('{idx: 8'(i), r: write_response_in});
            end
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    initial begin
        triple_t   e;
        resp_exp_t er;
        forever begin
            @(posedge clock);
            #1;
            if (rst) continue;
            if (write_command_out.valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 64'(write_command_out.valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("issue_cmd", 64'(write_command_out), 64'(e.cmd));
                    check("issue_data0", 64'(write_data_0_out), 64'(e.d0));
                    check("issue_data1", 64'(write_data_1_out), 64'(e.d1));
                end
            end else begin
                check("idle_cmd_zero", 64'(write_command_out), 64'(0));
                check("idle_data_zero", {write_data_0_out.data, write_data_1_out.data}, 64'(0));
            end
            for (int i = 0; i < N; i++) begin
                if (write_response_out[i].valid) begin
                    if (resp_q.size() == 0) begin
                        check($sformatf("unexpected_resp%0d", i), 64'(write_response_out[i].valid), 64'(0));
                    end else begin
                        er = resp_q.pop_front();
                        check("resp_port", 64'(i), 64'(er.idx));
                        check("resp_value", 64'(write_response_out[i]), 64'(er.r));
                    end
                end else begin
                    check($sformatf("resp%0d_zero", i), 64'(write_response_out[i]), 64'(0));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst                         = 1'b1;
        enabled_in                  = 1'b0;
        write_command_in            = '0;
        write_data_0_in             = '0;
        write_data_1_in             = '0;
        write_command_buffer_status = '0;
        write_response_in           = '0;
        #2;
        check("rst_ready", 64'(request_ready_out), 64'(0));
        check("rst_cmd", 64'(write_command_out), 64'(0));
        check("rst_data", {write_data_0_out.data, write_data_1_out.data}, 64'(0));
        check("rst_resp", 64'(write_response_out), 64'(0));
        check("rst_count", 64'(outstanding_count), 64'(0));
        check("rst_drained", 64'(drained_out), 64'(1));
        @(negedge clock);
        rst = 1'b0;

        // Disabled: a request is not granted.
        phase = 0;
        step(4'b0100, -1);
        check("disabled_drained", 64'(drained_out), 64'(1));
        en_drive = 1'b1;
        step(4'b0000, -1);

        // Only requester 2 from pointer 0: granted twice in a row.
        phase = 1;
        step(4'b0100, 2);
        check("active_drained", 64'(drained_out), 64'(0));
        step(4'b0100, 2);
        check("cnt_after1", 64'(outstanding_count), 64'(1));
        step(4'b0000, -1);
        check("cnt_after2", 64'(outstanding_count), 64'(2));
        step(4'b0000, -1, 1'b1, BASE + 8'd2, 8'h01);
        step(4'b0000, -1, 1'b1, BASE + 8'd2, 8'h02);
        check("cnt_resp1", 64'(outstanding_count), 64'(1));
        step(4'b0000, -1);
        check("cnt_zero", 64'(outstanding_count), 64'(0));

        // All requesting: alfull blocks, then rotation from pointer 3 until credits run out.
        phase = 2;
        af_drive = 1'b1;
        step(4'b1111, -1);
        af_drive = 1'b0;
        for (int k = 0; k < 32; k++) begin
`ifdef CU_WRITE_ARBITER_BURST_EN
            g = (3 + k / 4) % 4;
`else
            g = (3 + k) % 4;
`endif
            step(4'b1111, g);
        end
        step(4'b1111, -1);
        check("cnt_full", 64'(outstanding_count), 64'(32));
        step(4'b1111, -1);

        // Full boundary: response frees a credit for the following cycle only.
        step(4'b1111, -1, 1'b1, BASE + 8'd1, 8'h21);
        check("cnt_full_resp_cycle", 64'(outstanding_count), 64'(32));
        step(4'b1111, 3);
        check("cnt_31", 64'(outstanding_count), 64'(31));
        step(4'b0000, -1);
        check("cnt_refull", 64'(outstanding_count), 64'(32));

        // 27 responses, one with an unmatched cu_id (still returns a credit).
        for (int k = 0; k < 27; k++) begin
            step(4'b0000, -1, 1'b1, (k == 13) ? BASE + 8'(N) : BASE + 8'(k % 4), 8'(k));
        end
        step(4'b0000, -1);
        check("cnt_5", 64'(outstanding_count), 64'(5));

        // Grant and response in the same cycle leave the count unchanged.
        phase = 3;
        step(4'b0010, 1, 1'b1, BASE, 8'h50);
        check("cnt_same_cycle_start", 64'(outstanding_count), 64'(5));
        step(4'b0000, -1);
        check("cnt_same_cycle_after", 64'(outstanding_count), 64'(5));

        // Drain with 3 outstanding.
        step(4'b0000, -1, 1'b1, BASE + 8'd3, 8'h60);
        step(4'b0000, -1, 1'b1, BASE + 8'd2, 8'h61);
        en_drive = 1'b0;
        step(4'b0000, -1);
        check("cnt_3", 64'(outstanding_count), 64'(3));
        check("drain_enter_drained", 64'(drained_out), 64'(0));
        phase = 4;
        step(4'b1111, -1);
        check("drain_drained0", 64'(drained_out), 64'(0));
        step(4'b1111, -1, 1'b1, BASE + 8'd0, 8'h70);
        step(4'b1111, -1, 1'b1, BASE + 8'd1, 8'h71);
        check("drain_drained1", 64'(drained_out), 64'(0));
        step(4'b1111, -1, 1'b1, BASE + 8'd2, 8'h72);
        check("drain_drained2", 64'(drained_out), 64'(0));
        step(4'b1111, -1);
        check("drain_cnt0", 64'(outstanding_count), 64'(0));
        check("drain_resp_out_busy", 64'(drained_out), 64'(0));
        step(4'b0000, -1);
        check("drain_last_cycle", 64'(drained_out), 64'(0));

        // Response at zero credits is routed but does not wrap the counter.
        step(4'b0000, -1, 1'b1, BASE + 8'd3, 8'h80);
        check("drained_final", 64'(drained_out), 64'(1));
        check("cnt_zero_resp_start", 64'(outstanding_count), 64'(0));
        step(4'b0000, -1);
        check("cnt_no_wrap", 64'(outstanding_count), 64'(0));

        // Reset mid-operation clears in-flight outputs, credits and pointer.
        en_drive = 1'b1;
        phase = 5;
        step(4'b1111, -1);
        step(4'b1111, 2);
        @(negedge clock);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(request_ready_out), 64'(0));
        check("midrst_cmd", 64'(write_command_out), 64'(0));
        check("midrst_cnt", 64'(outstanding_count), 64'(0));
        check("midrst_drained", 64'(drained_out), 64'(1));
        @(negedge clock);
        rst = 1'b0;
        step(4'b1111, 0);
        step(4'b0000, -1);
        check("post_rst_cnt", 64'(outstanding_count), 64'(1));
        step(4'b0000, -1);
        step(4'b0000, -1);
        check("issue_queue_empty", 64'(exp_q.size()), 64'(0));
        check("resp_queue_empty", 64'(resp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cu_write_arbiter_control.md
Name: cu_write_arbiter_control

Overview:
- Shares one write command/data channel among NUM_REQUESTERS write engine controls.
- Each requester presents a command plus two data halves together. The block picks one requester per cycle by round-robin, issues its triple downstream to the command buffer, and limits outstanding writes with a credit counter.
- Write responses are routed back to the originating requester by cu_id.
- A drain state machine gives a clean quiesce when the block is disabled.

Parameters:
- NUM_REQUESTERS, 4, number of write engine controls sharing the channel (2..8).
- REQ_ID_BASE, DATA_WRITE_CONTROL_ID, cu_id of requester 0; requester i owns cu_id REQ_ID_BASE+i.
- MAX_OUTSTANDING, 32, maximum issued writes not yet answered by a response.

Ports:
- clock  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enabled_in  in  1  block enable (ACTIVE vs drain)
- write_command_in  in  NUM_REQUESTERS x CommandBufferLine  per-requester command; .valid is the request
- write_data_0_in  in  NUM_REQUESTERS x ReadWriteDataLine  first data half, qualified by command valid
- write_data_1_in  in  NUM_REQUESTERS x ReadWriteDataLine  second data half
- request_ready_out  out  NUM_REQUESTERS  accept strobe; the triple is consumed in the cycle it is high
- write_command_buffer_status  in  BufferStatus  downstream command buffer; .alfull blocks issue
- write_response_in  in  ResponseBufferLine  write response from the command/tag layer
- write_command_out  out  CommandBufferLine  arbitrated command
- write_data_0_out  out  ReadWriteDataLine  arbitrated data half 0
- write_data_1_out  out  ReadWriteDataLine  arbitrated data half 1
- write_response_out  out  NUM_REQUESTERS x ResponseBufferLine  demuxed responses
- outstanding_count  out  $clog2(MAX_OUTSTANDING+1)  current credit usage
- drained_out  out  1  high in DISABLED state

Behaviour:
- Reset: all outputs 0, except drained_out=1. State=DISABLED, rr pointer=0, outstanding=0.
- States:
  - DISABLED -> ACTIVE when enabled_in=1.
  - ACTIVE -> DRAIN when enabled_in=0.
  - DRAIN -> DISABLED when outstanding==0 and no output is valid.
  - DRAIN -> ACTIVE if enabled_in returns to 1.
- can_issue = state==ACTIVE && ~write_command_buffer_status.alfull && outstanding<MAX_OUTSTANDING.
- Grant selection:
  - Combinational round-robin, starting at the rr pointer, over write_command_in[i].valid.
  - request_ready_out is one-hot, or all 0 when ~can_issue or there is no request.
  - Requesters hold the triple stable until ready.
- Pointer update: after a grant to i, the pointer becomes (i+1) mod NUM_REQUESTERS. It is unchanged when there is no grant.
- Latency: the granted triple appears registered on the *_out ports 1 cycle after ready. Valid on outputs lasts exactly one cycle per grant; outputs are zeroed when there is no grant.
- Command and data are passed through unmodified; cu_id is not rewritten.
- outstanding counter:
  - +1 on grant; -1 on write_response_in.valid; unchanged when both occur in the same cycle.
  - Never wraps: a response at 0 is ignored.
- Response routing: write_response_out[i] is registered (1 cycle) and equals write_response_in when .valid && cmd.cu_id==REQ_ID_BASE+i, else 0. A response with an unmatched cu_id still decrements the credit counter and is dropped.
- Full boundary: at outstanding==MAX_OUTSTANDING, no grant. A response in that cycle frees a credit for the next cycle, not the same cycle.
- Reset mid-operation: all state clears immediately, and in-flight outputs drop to 0.

Optional Feature:
- CU_WRITE_ARBITER_BURST_EN:
  - With the macro: the winner keeps priority for up to 4 consecutive grants while it keeps requesting, tracked by a 2-bit burst counter. The pointer advances past the winner after the 4th grant or when its request drops.
  - Without the macro: the pointer advances after every grant (pure round-robin), and no burst counter exists.

Decomposition:
- CU_PKG gets:
  - the arbiter state enum (DISABLED, ACTIVE, DRAIN);
  - WRITE_ARB_MAX_OUTSTANDING;
  - WRITE_ARB_BURST_LEN=4.
- Existing CommandBufferLine/ReadWriteDataLine/ResponseBufferLine/BufferStatus types are reused.
- Sub-module: round_robin_priority_arbiter_N_input (request vector + pointer -> one-hot grant), reusable by read-side controllers.

Test Plan:
- Requesters 0..3 all valid continuously, alfull=0, no responses -> grants in order 0,1,2,3,0,..., outputs valid one cycle after each ready, and grants stop with outstanding=32.
- Only requester 2 valid, pointer=0 -> ready[2] in the first cycle; the next grant again goes to 2; the pointer moves to 3 after each grant.
- outstanding=32 and one response with cu_id=REQ_ID_BASE+1 -> write_response_out[1].valid the next cycle, outstanding=31, and a new grant the cycle after.
- Grant and response in the same cycle at outstanding=5 -> outstanding stays 5.
- enabled_in dropped with 3 outstanding -> no further ready, state DRAIN, drained_out=1 only after the 3rd response.
- With CU_WRITE_ARBITER_BURST_EN, requesters 0 and 1 both valid -> grants 0,0,0,0,1,1,1,1.
